// File: rtl/lzd_normalizer.sv
// rtl/lzd_normalizer.sv - two-stage pipelined leading-zero normalizer (A << lzc), valid/ready on both sides.
// Optional saturating zero-result transfer counter enabled by LZD_NORM_ZERO_CNT_EN.

module prefix_and #(
    parameter int width = 8,
    parameter bit speed = 1'b1
) (
    input  logic [width-1:0] x,
    output logic [width-1:0] y
);
    // y[i] = &x[width-1:i]; speed=1 selects a log-depth parallel prefix, speed=0 a ripple chain.
    localparam int LV = $clog2(width);

    generate
        if (speed) begin : g_fast
            always_comb begin
                logic [width-1:0] cur;
                logic [width-1:0] nxt;
                cur = x;
                nxt = x;
                for (int k = 0; k < LV; k++) begin
                    for (int i = 0; i < width; i++) begin
                        if (i + (1 << k) < width) begin
                            nxt[i] = cur[i] & cur[i + (1 << k)];
                        end else begin
                            nxt[i] = cur[i];
                        end
                    end
                    cur = nxt;
                end
                y = cur;
            end
        end else begin : g_slow
            always_comb begin
                logic acc;
                acc = 1'b1;
                y   = '0;
                for (int i = width - 1; i >= 0; i--) begin
                    acc  = acc & x[i];
                    y[i] = acc;
                end
            end
        end
    endgenerate
endmodule

module lead_zero_det #(
    parameter int width = 8,
    parameter bit speed = 1'b1
) (
    input  logic [width-1:0] a,
    output logic [width-1:0] onehot
);
    // all_zero_above[j] is set when every bit above position j is zero.
    logic [width-2:0] all_zero_above;

    prefix_and #(
        .width(width - 1),
        .speed(speed)
    ) u_prefix (
        .x(~a[width-1:1]),
        .y(all_zero_above)
    );

    always_comb begin
        onehot            = '0;
        onehot[width-1]   = a[width-1];
        for (int i = 0; i < width - 1; i++) begin
            onehot[i] = a[i] & all_zero_above[i];
        end
    end
endmodule

module lzd_normalizer #(
    parameter int width = 8,
    parameter bit speed = 1'b1,
    localparam int CW = $clog2(width + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] A_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] Z_o,
    output logic [CW-1:0]    cnt_o,
    output logic             zero_o
`ifdef LZD_NORM_ZERO_CNT_EN
    ,
    output logic [15:0]      zero_cnt_o
`endif
);
    logic [width-1:0] onehot;
    logic [CW-1:0]    lzc;

    logic             s1_valid;
    logic [width-1:0] s1_a;
    logic [CW-1:0]    s1_cnt;
    logic             s1_zero;
    logic             s2_valid;

    logic             s1_adv;
    logic             s2_adv;

    lead_zero_det #(
        .width(width),
        .speed(speed)
    ) u_lzd (
        .a(A_i),
        .onehot(onehot)
    );

    // One-hot at position p means width-1-p leading zeros; no bit set means the operand is zero.
    always_comb begin
        lzc = CW'(width);
        for (int p = 0; p < width; p++) begin
            if (onehot[p]) begin
                lzc = CW'(width - 1 - p);
            end
        end
    end

    assign s2_adv      = ~s2_valid | out_ready_i;
    assign s1_adv      = ~s1_valid | s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_cnt   <= '0;
            s1_zero  <= 1'b0;
            s2_valid <= 1'b0;
            Z_o      <= '0;
            cnt_o    <= '0;
            zero_o   <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    Z_o    <= s1_a << s1_cnt;
                    cnt_o  <= s1_cnt;
                    zero_o <= s1_zero;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    s1_a    <= A_i;
                    s1_cnt  <= lzc;
                    s1_zero <= (A_i == '0);
                end
            end
        end
    end

`ifdef LZD_NORM_ZERO_CNT_EN
    // A flush discards the item in the output stage, so that transfer is not counted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            zero_cnt_o <= '0;
        end else if (s2_valid && out_ready_i && !flush_i && zero_o && (zero_cnt_o != 16'hFFFF)) begin
            zero_cnt_o <= zero_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_lzd_normalizer.sv
// tb/tb_lzd_normalizer.sv - randomized self-checking bench for lzd_normalizer against a queue-based reference model.

module tb_lzd_normalizer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  z;
    logic [CW-1:0] cnt;
    logic          zero;
`ifdef LZD_NORM_ZERO_CNT_EN
    logic [15:0]   zero_cnt;
`endif

    lzd_normalizer #(.width(W)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .A_i(a),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .Z_o(z),
        .cnt_o(cnt),
        .zero_o(zero)
`ifdef LZD_NORM_ZERO_CNT_EN
        ,
        .zero_cnt_o(zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: items in flight in arrival order with the cycle index they were accepted in.
    logic [W-1:0] q_a[$];
    int           q_t[$];
    int           cyc = 0;
    int           zc_model = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_z;
    logic [CW-1:0] prev_cnt;
    logic         prev_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_lzc(input logic [W-1:0] v);
        int n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] ref_norm(input logic [W-1:0] v);
        int n = ref_lzc(v);
        return (n >= W) ? '0 : W'(v << n);
    endfunction

    task automatic cycle(input bit iv, input logic [W-1:0] av, input bit orr, input bit fl);
        bit exp_ready;
        bit exp_ov;
        bit ox;
        bit ix;
        in_valid  = iv;
        a         = av;
        out_ready = orr;
        flush     = fl;
        @(negedge clk);
        exp_ready = (q_a.size() < 2) || orr;
        exp_ov    = (q_a.size() > 0) && (cyc >= q_t[0] + 2);
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, exp_ov);
        if (prev_stall) begin
            check("stall_z", z, prev_z);
            check("stall_cnt", cnt, prev_cnt);
            check("stall_zero", zero, prev_zero);
        end
        if (exp_ov && out_valid) begin
            check("z", z, ref_norm(q_a[0]));
            check("cnt", cnt, ref_lzc(q_a[0]));
            check("zero", zero, q_a[0] == '0);
        end
        ox         = exp_ov && orr && !fl;
        ix         = iv && exp_ready && !fl;
        prev_stall = exp_ov && !orr && !fl;
        prev_z     = z;
        prev_cnt   = cnt;
        prev_zero  = zero;
        if (ox && q_a[0] == '0 && zc_model < 16'hFFFF) zc_model++;
        @(posedge clk);
        #1;
        if (fl) begin
            q_a.delete();
            q_t.delete();
        end else begin
            if (ox) begin
                void'(q_a.pop_front());
                void'(q_t.pop_front());
            end
            if (ix) begin
                q_a.push_back(av);
                q_t.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.delete();
        q_t.delete();
        prev_stall = 1'b0;
        zc_model   = 0;
        cyc++;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_z", z, '0);
        check("rst_cnt", cnt, '0);
        check("rst_zero", zero, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef LZD_NORM_ZERO_CNT_EN
        check("rst_zero_cnt", zero_cnt, 16'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] v;
        do_reset();

        // Single operand, unstalled: result appears two cycles after acceptance.
        cycle(1, 8'b0001_0110, 1, 0);
        cycle(0, 8'h00, 1, 0);
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_z", z, 8'b1011_0000);
        check("lat_cnt", cnt, 3);
        cycle(0, 8'h00, 1, 0);

        // Back-to-back boundary operands.
        cycle(1, 8'h80, 1, 0);
        cycle(1, 8'h01, 1, 0);
        cycle(1, 8'h00, 1, 0);
        repeat (3) cycle(0, 8'h00, 1, 0);

        // Backpressure: third item held off until the consumer resumes.
        cycle(1, 8'h23, 0, 0);
        cycle(1, 8'h05, 0, 0);
        repeat (3) cycle(1, 8'h7f, 0, 0);
        check("full_in_ready", in_ready, 1'b0);
        cycle(1, 8'h7f, 1, 0);
        repeat (4) cycle(0, 8'h00, 1, 0);

        // Flush with two in flight and a concurrent input.
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h00, 0, 0);
        cycle(1, 8'h02, 0, 1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        repeat (3) cycle(0, 8'h00, 1, 0);

        // Reset mid-stream, then normal operation resumes.
        cycle(1, 8'h09, 0, 0);
        cycle(1, 8'h00, 0, 0);
        do_reset();
        cycle(1, 8'h40, 1, 0);
        cycle(0, 8'h00, 1, 0);
        check("post_rst_cnt", cnt, 1);
        check("post_rst_z", z, 8'h80);
        cycle(0, 8'h00, 1, 0);

        // Randomized traffic with stalls, flushes and boundary-heavy operands.
        for (int n = 0; n < 12000; n++) begin
            case ($urandom_range(0, 5))
                0: v = '0;
                1: v = W'(1) << $urandom_range(0, W - 1);
                default: v = W'($urandom);
            endcase
            cycle(($urandom_range(0, 3) != 0), v, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 49) == 0));
        end
        repeat (4) cycle(0, 8'h00, 1, 0);
        check("drained", q_a.size(), 0);
`ifdef LZD_NORM_ZERO_CNT_EN
        check("zero_cnt", zero_cnt, zc_model);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
